// File: rtl/inst_fetcher_pkg.sv
// ============================================================================
// inst_fetcher_pkg
// Shared fetch-stage types: FSM encodings, BHT sizing and counter helpers.
// Revision: 1.0
// ============================================================================
`default_nettype none

package inst_fetcher_pkg;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_READY   = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_t;

  localparam int         c_bht_bits_default = 6;
  localparam logic [1:0] c_bht_cnt_reset    = 2'b01;

  function automatic logic [1:0] bht_next(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == 2'b11) ? cnt : cnt + 2'd1;
    else       return (cnt == 2'b00) ? cnt : cnt - 2'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/branch_predictor.sv
// ============================================================================
// branch_predictor
// Branch history table of 2-bit saturating counters, one read and one update port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module branch_predictor
  import inst_fetcher_pkg::*;
#(
  parameter int BHT_BITS = c_bht_bits_default
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic [BHT_BITS-1:0] rd_idx,
  output logic                rd_taken,
  input  logic                upd_valid,
  input  logic [BHT_BITS-1:0] upd_idx,
  input  logic                upd_taken
);

  localparam int c_entries = 1 << BHT_BITS;

  logic [1:0] r_bht [c_entries];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < c_entries; i++) r_bht[i] <= c_bht_cnt_reset;
    end else if (rdy_in && upd_valid) begin
      r_bht[upd_idx] <= bht_next(r_bht[upd_idx], upd_taken);
    end
  end

  // Read comes straight from the registers, so a same-cycle update is not yet visible.
  assign rd_taken = r_bht[rd_idx][1];

endmodule

`default_nettype wire

// File: rtl/inst_fetcher.sv
// ============================================================================
// inst_fetcher
// Single-outstanding instruction fetch FSM with flush handling and BHT prediction.
// Revision: 1.0
// ============================================================================
`default_nettype none

module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          BHT_BITS = c_bht_bits_default
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        fetch_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        pred_res,
  input  logic        issue_ready,
  input  logic        pc_change_flag,
  input  logic [31:0] pc_change_value,
  input  logic        rob_flush,
  input  logic [31:0] rob_flush_pc,
  input  logic        br_update_valid,
  input  logic [31:0] br_update_pc,
  input  logic        br_update_taken
);

  fetch_state_t r_state, w_state_next;
  logic [31:0]  r_fetch_pc, w_fetch_pc_next;
  logic [31:0]  r_pc, w_pc_next;
  logic [31:0]  r_inst, w_inst_next;
  logic         w_unused_upd_bits;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state    <= ST_FETCH;
      r_fetch_pc <= RESET_PC;
      r_pc       <= RESET_PC;
      r_inst     <= 32'h0;
    end else if (rdy_in) begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
      r_pc       <= w_pc_next;
      r_inst     <= w_inst_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    w_pc_next       = r_pc;
    w_inst_next     = r_inst;
    case (r_state)
      ST_FETCH: begin
        if (rob_flush) begin
          // A response landing with the flush is stale and already consumed.
          w_fetch_pc_next = rob_flush_pc;
          w_state_next    = mem_resp_valid ? ST_FETCH : ST_DISCARD;
        end else if (mem_resp_valid) begin
          w_inst_next  = mem_resp_data;
          w_pc_next    = r_fetch_pc;
          w_state_next = ST_READY;
        end
      end
      ST_READY: begin
        if (rob_flush) begin
          w_fetch_pc_next = rob_flush_pc;
          w_state_next    = ST_FETCH;
        end else if (issue_ready) begin
          w_fetch_pc_next = pc_change_flag ? pc_change_value : r_pc + 32'd4;
          w_state_next    = ST_FETCH;
        end
      end
      ST_DISCARD: begin
        if (rob_flush) w_fetch_pc_next = rob_flush_pc;
        if (mem_resp_valid) w_state_next = ST_FETCH;
      end
      default: w_state_next = ST_FETCH;
    endcase
  end

  assign mem_req_valid = (r_state == ST_FETCH);
  assign mem_req_addr  = r_fetch_pc;
  assign fetch_ready   = (r_state == ST_READY);
  assign inst          = r_inst;
  assign pc            = r_pc;

  assign w_unused_upd_bits = ^{br_update_pc[31:BHT_BITS+2], br_update_pc[1:0]};

  branch_predictor #(
    .BHT_BITS (BHT_BITS)
  ) u_bp (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .rd_idx    (r_pc[BHT_BITS+1:2]),
    .rd_taken  (pred_res),
    .upd_valid (br_update_valid),
    .upd_idx   (br_update_pc[BHT_BITS+1:2]),
    .upd_taken (br_update_taken)
  );

endmodule

`default_nettype wire

// File: tb/tb_inst_fetcher.sv
// ============================================================================
// tb_inst_fetcher
// Directed bench for inst_fetcher with a 3-cycle-latency memory driven inline.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_inst_fetcher;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        fetch_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        pred_res;
  logic        issue_ready;
  logic        pc_change_flag;
  logic [31:0] pc_change_value;
  logic        rob_flush;
  logic [31:0] rob_flush_pc;
  logic        br_update_valid;
  logic [31:0] br_update_pc;
  logic        br_update_taken;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_in = ~clk_in;

  inst_fetcher u_dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .rdy_in          (rdy_in),
    .mem_req_valid   (mem_req_valid),
    .mem_req_addr    (mem_req_addr),
    .mem_resp_valid  (mem_resp_valid),
    .mem_resp_data   (mem_resp_data),
    .fetch_ready     (fetch_ready),
    .inst            (inst),
    .pc              (pc),
    .pred_res        (pred_res),
    .issue_ready     (issue_ready),
    .pc_change_flag  (pc_change_flag),
    .pc_change_value (pc_change_value),
    .rob_flush       (rob_flush),
    .rob_flush_pc    (rob_flush_pc),
    .br_update_valid (br_update_valid),
    .br_update_pc    (br_update_pc),
    .br_update_taken (br_update_taken)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Entered in the first cycle of a request; response pulses 3 cycles later.
  task automatic serve(input string tag, input logic [31:0] addr, input logic [31:0] data);
    check({tag, "_req_valid"}, {31'd0, mem_req_valid}, 32'd1);
    check({tag, "_req_addr"}, mem_req_addr, addr);
    tick();
    tick();
    check({tag, "_addr_stable"}, mem_req_addr, addr);
    tick();
    check({tag, "_not_ready_yet"}, {31'd0, fetch_ready}, 32'd0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = data;
    tick();
    mem_resp_valid = 1'b0;
    check({tag, "_ready"}, {31'd0, fetch_ready}, 32'd1);
    check({tag, "_inst"}, inst, data);
    check({tag, "_pc"}, pc, addr);
    check({tag, "_req_dropped"}, {31'd0, mem_req_valid}, 32'd0);
  endtask

  task automatic issue(input logic flag, input logic [31:0] target);
    issue_ready     = 1'b1;
    pc_change_flag  = flag;
    pc_change_value = target;
    tick();
    issue_ready     = 1'b0;
    pc_change_flag  = 1'b0;
  endtask

  task automatic bht_update(input logic taken, input logic [31:0] exp_before, input logic [31:0] exp_after, input string tag);
    br_update_valid = 1'b1;
    br_update_pc    = 32'h40;
    br_update_taken = taken;
    #1;
    check({tag, "_pre"}, {31'd0, pred_res}, exp_before);
    tick();
    br_update_valid = 1'b0;
    check({tag, "_post"}, {31'd0, pred_res}, exp_after);
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1;
    mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
    issue_ready = 1'b0; pc_change_flag = 1'b0; pc_change_value = 32'h0;
    rob_flush = 1'b0; rob_flush_pc = 32'h0;
    br_update_valid = 1'b0; br_update_pc = 32'h0; br_update_taken = 1'b0;
    #12;
    check("rst_req_valid", {31'd0, mem_req_valid}, 32'd1);
    check("rst_req_addr", mem_req_addr, 32'h0);
    check("rst_fetch_ready", {31'd0, fetch_ready}, 32'd0);
    check("rst_inst", inst, 32'h0);
    check("rst_pc", pc, 32'h0);
    @(negedge clk_in);
    rst_in = 1'b1;
    tick();

    serve("f0", 32'h0, 32'h00000013);

    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_inst", inst, 32'h00000013);
      check("hold_pc", pc, 32'h0);
      check("hold_ready", {31'd0, fetch_ready}, 32'd1);
    end
    issue(1'b0, 32'h0);
    check("next_addr4", mem_req_addr, 32'h4);
    check("next_ready_low", {31'd0, fetch_ready}, 32'd0);

    serve("f4", 32'h4, 32'h00100093);
    issue(1'b0, 32'h0);
    check("next_addr8", mem_req_addr, 32'h8);
    tick();
    rob_flush = 1'b1; rob_flush_pc = 32'h180;
    tick();
    rob_flush = 1'b0;
    check("discard_no_req", {31'd0, mem_req_valid}, 32'd0);
    check("discard_not_ready", {31'd0, fetch_ready}, 32'd0);
    rob_flush = 1'b1; rob_flush_pc = 32'h200;
    tick();
    rob_flush = 1'b0;
    check("discard_stays", {31'd0, mem_req_valid}, 32'd0);
    mem_resp_valid = 1'b1; mem_resp_data = 32'hDEADBEEF;
    tick();
    mem_resp_valid = 1'b0;
    check("stale_dropped_inst", inst, 32'h00100093);
    check("stale_not_ready", {31'd0, fetch_ready}, 32'd0);
    serve("f200", 32'h200, 32'h11111111);
    check("pred_init", {31'd0, pred_res}, 32'd0);

    issue(1'b1, 32'h100);
    serve("f100", 32'h100, 32'h00000063);
    bht_update(1'b1, 32'd0, 32'd0, "tk1");
    bht_update(1'b1, 32'd0, 32'd0, "tk2");
    bht_update(1'b1, 32'd0, 32'd0, "tk3");
    issue(1'b1, 32'h40);
    serve("f40", 32'h40, 32'h00000463);
    check("pred_taken", {31'd0, pred_res}, 32'd1);
    bht_update(1'b0, 32'd1, 32'd1, "nt1");
    bht_update(1'b0, 32'd1, 32'd0, "nt2");
    bht_update(1'b0, 32'd0, 32'd0, "nt3");
    bht_update(1'b0, 32'd0, 32'd0, "nt4_sat");
    bht_update(1'b1, 32'd0, 32'd0, "tk_from0");
    bht_update(1'b1, 32'd0, 32'd1, "tk_from1");

    rdy_in = 1'b0;
    issue_ready = 1'b1;
    br_update_valid = 1'b1; br_update_pc = 32'h40; br_update_taken = 1'b0;
    tick();
    tick();
    check("frz_ready", {31'd0, fetch_ready}, 32'd1);
    check("frz_no_req", {31'd0, mem_req_valid}, 32'd0);
    check("frz_pred", {31'd0, pred_res}, 32'd1);
    issue_ready = 1'b0; br_update_valid = 1'b0;
    rdy_in = 1'b1;

    rob_flush = 1'b1; rob_flush_pc = 32'hFFFFFFFC;
    tick();
    rob_flush = 1'b0;
    check("flush_ready_low", {31'd0, fetch_ready}, 32'd0);
    rdy_in = 1'b0;
    tick();
    tick();
    check("frz_fetch_req", {31'd0, mem_req_valid}, 32'd1);
    rdy_in = 1'b1;
    serve("ffc", 32'hFFFFFFFC, 32'h22222222);
    issue(1'b0, 32'h0);
    check("wrap_addr", mem_req_addr, 32'h0);

    tick();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h33333333;
    rob_flush = 1'b1; rob_flush_pc = 32'h80;
    tick();
    mem_resp_valid = 1'b0; rob_flush = 1'b0;
    check("flush_resp_req", {31'd0, mem_req_valid}, 32'd1);
    check("flush_resp_addr", mem_req_addr, 32'h80);
    check("flush_resp_inst", inst, 32'h22222222);
    serve("f80", 32'h80, 32'h44444444);

    issue(1'b0, 32'h0);
    check("next_addr84", mem_req_addr, 32'h84);
    #2 rst_in = 1'b0;
    #1;
    check("arst_addr", mem_req_addr, 32'h0);
    check("arst_pc", pc, 32'h0);
    check("arst_inst", inst, 32'h0);
    @(negedge clk_in);
    rst_in = 1'b1;
    tick();
    serve("r0", 32'h0, 32'h55555555);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/inst_fetcher.md
INST_FETCHER -- requirements
Module: inst_fetcher

Interface
REQ-001 Parameter RESET_PC, default 32'h0: PC loaded on reset.
REQ-002 Parameter BHT_BITS, default 6: log2 of branch-history-table entries.
REQ-003 clk_in  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_in  input  1  reset, asynchronous, active-low.
REQ-005 rdy_in  input  1  global ready; low freezes all state.
REQ-006 mem_req_valid  output  1  instruction word read request.
REQ-007 mem_req_addr  output  32  word address of the request.
REQ-008 mem_resp_valid  input  1  one-cycle pulse: response data valid.
REQ-009 mem_resp_data  input  32  returned instruction word.
REQ-010 fetch_ready  output  1  inst/pc hold a valid instruction for the decoder.
REQ-011 inst  output  32  latched instruction word.
REQ-012 pc  output  32  address of inst.
REQ-013 pred_res  output  1  predicted taken for the instruction at pc.
REQ-014 issue_ready  input  1  decoder consumes inst this cycle.
REQ-015 pc_change_flag  input  1  decoder redirect (jal or predicted-taken branch).
REQ-016 pc_change_value  input  32  redirect target.
REQ-017 rob_flush  input  1  mispredict flush.
REQ-018 rob_flush_pc  input  32  correct PC after a flush.
REQ-019 br_update_valid  input  1  committed conditional branch.
REQ-020 br_update_pc  input  32  PC of the committed branch.
REQ-021 br_update_taken  input  1  actual outcome of the committed branch.

Function
REQ-022 FSM states: FETCH (request outstanding), READY (instruction held), DISCARD (drop stale response).
REQ-023 FETCH: mem_req_valid=1 and mem_req_addr=fetch_pc; on mem_resp_valid, latch inst<=mem_resp_data and pc<=fetch_pc, then go to READY.
REQ-024 Only one request is outstanding at a time; mem_req_addr stays stable until the response arrives.
REQ-025 READY: fetch_ready=1 and mem_req_valid=0; on issue_ready, fetch_pc<=pc_change_flag ? pc_change_value : pc+4 (mod 2^32), then go to FETCH.
REQ-026 In READY without issue_ready, inst/pc/pred_res hold their values.
REQ-027 rob_flush has priority over every other event: fetch_pc<=rob_flush_pc and fetch_ready drops to 0 in the next cycle.
REQ-028 rob_flush in FETCH with no mem_resp_valid in the same cycle -> DISCARD.
REQ-029 rob_flush in READY, or in FETCH with mem_resp_valid in the same cycle -> FETCH, and that response is dropped.
REQ-030 DISCARD: mem_req_valid=0; the next mem_resp_valid is dropped, then go to FETCH.
REQ-031 rob_flush in DISCARD updates fetch_pc only and the state stays DISCARD.
REQ-032 pred_res = MSB of BHT[pc[BHT_BITS+1:2]]; combinational from the latched pc.
REQ-033 BHT entries are 2-bit saturating counters; br_update_valid updates entry br_update_pc[BHT_BITS+1:2]: +1 if taken, -1 if not, saturating at 0 and 3.
REQ-034 BHT read and update of the same entry in the same cycle: pred_res shows the pre-update value.
REQ-035 rdy_in=0: no state, PC or BHT change; responses arriving during that cycle are lost, and the memory side must not pulse mem_resp_valid while rdy_in=0.
REQ-036 Latency: request to fetch_ready = memory latency + 1 cycle; issue to next request = 1 cycle.

Reset
REQ-037 rst_in low, asynchronously: state=FETCH, fetch_pc=RESET_PC, pc=RESET_PC, inst=32'h0, fetch_ready=0, all BHT counters=2'b01.
REQ-038 Reset mid-request: the pending response is not dropped; the memory side is reset by the same signal.
REQ-039 Immediately after reset, mem_req_valid=1 and mem_req_addr=RESET_PC.

Structure
REQ-040 FSM state encodings, the BHT_BITS default and the counter reset value live in the shared CPU package.
REQ-041 The BHT is one sub-module, branch_predictor: read port keyed by pc, update port keyed by br_update_*.

Verification
REQ-042 Reset, memory latency 3, word 32'h00000013 at address 0 -> request addr 0; fetch_ready=1 in cycle 4 with inst=32'h00000013, pc=0.
REQ-043 issue_ready held at 0 for 5 cycles, then pulsed -> inst/pc stable throughout; next request addr 4.
REQ-044 Issue with pc_change_flag=1, pc_change_value=32'h100 -> next mem_req_addr=32'h100.
REQ-045 rob_flush, rob_flush_pc=32'h200 while the request for addr 8 is pending -> state DISCARD; the response for 8 is never presented; next request addr 32'h200.
REQ-046 Three br_update_taken=1 updates at br_update_pc=32'h40, then pc=32'h40 -> pred_res=1; four not-taken updates -> pred_res=0, counter saturates at 0.
REQ-047 pc=32'hFFFFFFFC issued without redirect -> next request addr 32'h0.
